// File: rtl/pad_io_ctrl.sv
// pad_io_ctrl: clocked pad-control layer between the core and the pad wrappers.
// Inputs are synchronised and optionally debounced before reaching the core.
// Outputs, output-enables and attributes are registered toward the pads.
// A sleep/retention handshake freezes pad state while the core is held.
module pad_io_ctrl #(
  parameter int NPads      = 20,
  parameter int AttrDw     = 8,
  parameter int SyncStages = 2,
  parameter int DebW       = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NPads-1:0]        pad_in_i,
  output logic [NPads-1:0]        core_in_o,
  input  logic [NPads-1:0]        core_out_i,
  input  logic [NPads-1:0]        core_oe_i,
  input  logic [NPads*AttrDw-1:0] attr_i,
  output logic [NPads-1:0]        pad_out_o,
  output logic [NPads-1:0]        pad_oe_o,
  output logic [NPads*AttrDw-1:0] pad_attr_o,
  input  logic [NPads-1:0]        deb_en_i,
  input  logic [DebW-1:0]         deb_thr_i,
  input  logic [NPads*2-1:0]      sleep_mode_i,
  input  logic                    sleep_req_i,
  output logic                    sleep_ack_o
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FREEZE = 2'd1,
    ST_SLEEP  = 2'd2,
    ST_WAKE   = 2'd3
  } state_e;

  // Wake counter must count SyncStages cycles so the synchronisers refill.
  localparam int WakeW = (SyncStages > 1) ? $clog2(SyncStages) : 1;
  localparam logic [WakeW-1:0] WakeLast = WakeW'(SyncStages - 1);

  state_e                    state_q;
  logic [WakeW-1:0]          wake_cnt_q;
  logic                      sleep_ack_q;
  logic [NPads-1:0]          hold_out_q;
  logic [NPads-1:0]          hold_oe_q;
  logic [NPads*AttrDw-1:0]   hold_attr_q;

  logic [SyncStages-1:0][NPads-1:0] sync_q;
  logic [NPads-1:0]          synced;

  logic [NPads-1:0]          core_in_q, core_in_d;
  logic [DebW-1:0]           deb_cnt_q [NPads];
  logic [DebW-1:0]           deb_cnt_d [NPads];
  logic [DebW-1:0]           thr_eff;

  logic [NPads-1:0]          pad_out_q, pad_out_d;
  logic [NPads-1:0]          pad_oe_q, pad_oe_d;
  logic [NPads*AttrDw-1:0]   pad_attr_q, pad_attr_d;

  // True when this cycle's mismatch completes the required persistence.
  function automatic logic deb_hit(input logic [DebW-1:0] cnt,
                                   input logic [DebW-1:0] thr);
    logic [DebW:0] cnt_inc;
    cnt_inc = {1'b0, cnt} + {{DebW{1'b0}}, 1'b1};
    return (cnt_inc >= {1'b0, thr});
  endfunction

  // Retention drive for one pad; returns {oe, out}.
  function automatic logic [1:0] retain(input logic [1:0] mode,
                                        input logic       held_out,
                                        input logic       held_oe);
    logic [1:0] r;
    case (mode)
      2'd0:    r = {held_oe, held_out};
      2'd1:    r = {1'b0, held_out};
      2'd2:    r = {1'b1, 1'b0};
      default: r = {1'b1, 1'b1};
    endcase
    return r;
  endfunction

  assign synced  = sync_q[SyncStages-1];
  assign thr_eff = (deb_thr_i == '0) ? {{(DebW-1){1'b0}}, 1'b1} : deb_thr_i;

  // Input synchroniser chain; keeps sampling in every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pad_in_i;
      for (int i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Debounce / pass-through decision per pad; frozen outside ACTIVE.
  always_comb begin
    core_in_d = core_in_q;
    for (int k = 0; k < NPads; k++) begin
      deb_cnt_d[k] = '0;
      if (state_q == ST_ACTIVE) begin
        if (!deb_en_i[k]) begin
          core_in_d[k] = synced[k];
        end else if (synced[k] != core_in_q[k]) begin
          if (deb_hit(deb_cnt_q[k], thr_eff)) begin
            core_in_d[k] = synced[k];
          end else begin
            deb_cnt_d[k] = deb_cnt_q[k] + DebW'(1);
          end
        end
      end
    end
  end

  // Core-side input register and debounce counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_in_q <= '0;
      for (int k = 0; k < NPads; k++) begin
        deb_cnt_q[k] <= '0;
      end
    end else begin
      core_in_q <= core_in_d;
      for (int k = 0; k < NPads; k++) begin
        deb_cnt_q[k] <= deb_cnt_d[k];
      end
    end
  end

  // Sleep handshake FSM with hold capture and registered acknowledge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ACTIVE;
      wake_cnt_q  <= '0;
      sleep_ack_q <= 1'b0;
      hold_out_q  <= '0;
      hold_oe_q   <= '0;
      hold_attr_q <= '0;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (sleep_req_i) begin
            state_q     <= ST_FREEZE;
            hold_out_q  <= core_out_i;
            hold_oe_q   <= core_oe_i;
            hold_attr_q <= attr_i;
          end
        end
        ST_FREEZE: begin
          state_q     <= ST_SLEEP;
          sleep_ack_q <= 1'b1;
        end
        ST_SLEEP: begin
          if (!sleep_req_i) begin
            state_q     <= ST_WAKE;
            sleep_ack_q <= 1'b0;
            wake_cnt_q  <= '0;
          end
        end
        ST_WAKE: begin
          if (wake_cnt_q == WakeLast) begin
            state_q <= ST_ACTIVE;
          end else begin
            wake_cnt_q <= wake_cnt_q + WakeW'(1);
          end
        end
        default: begin
          state_q     <= ST_ACTIVE;
          sleep_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // Pad drive selection: live core values in ACTIVE, retention otherwise.
  always_comb begin
    pad_out_d  = core_out_i;
    pad_oe_d   = core_oe_i;
    pad_attr_d = attr_i;
    if (state_q != ST_ACTIVE) begin
      pad_attr_d = hold_attr_q;
      for (int k = 0; k < NPads; k++) begin
        {pad_oe_d[k], pad_out_d[k]} =
          retain(sleep_mode_i[2*k +: 2], hold_out_q[k], hold_oe_q[k]);
      end
    end
  end

  // Registered pad-side outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_out_q  <= '0;
      pad_oe_q   <= '0;
      pad_attr_q <= '0;
    end else begin
      pad_out_q  <= pad_out_d;
      pad_oe_q   <= pad_oe_d;
      pad_attr_q <= pad_attr_d;
    end
  end

  assign core_in_o   = core_in_q;
  assign pad_out_o   = pad_out_q;
  assign pad_oe_o    = pad_oe_q;
  assign pad_attr_o  = pad_attr_q;
  assign sleep_ack_o = sleep_ack_q;

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Directed bench for pad_io_ctrl with 4 pads, 2 sync stages, 8-bit threshold.
module tb_pad_io_ctrl;

  localparam int NPads      = 4;
  localparam int AttrDw     = 8;
  localparam int SyncStages = 2;
  localparam int DebW       = 8;

  logic                    clk;
  logic                    rst_ni;
  logic [NPads-1:0]        pad_in;
  logic [NPads-1:0]        core_in;
  logic [NPads-1:0]        core_out;
  logic [NPads-1:0]        core_oe;
  logic [NPads*AttrDw-1:0] attr;
  logic [NPads-1:0]        pad_out;
  logic [NPads-1:0]        pad_oe;
  logic [NPads*AttrDw-1:0] pad_attr;
  logic [NPads-1:0]        deb_en;
  logic [DebW-1:0]         deb_thr;
  logic [NPads*2-1:0]      sleep_mode;
  logic                    sleep_req;
  logic                    sleep_ack;

  int errors = 0;
  int checks = 0;

  pad_io_ctrl #(
    .NPads(NPads), .AttrDw(AttrDw), .SyncStages(SyncStages), .DebW(DebW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .pad_in_i(pad_in),
    .core_in_o(core_in),
    .core_out_i(core_out),
    .core_oe_i(core_oe),
    .attr_i(attr),
    .pad_out_o(pad_out),
    .pad_oe_o(pad_oe),
    .pad_attr_o(pad_attr),
    .deb_en_i(deb_en),
    .deb_thr_i(deb_thr),
    .sleep_mode_i(sleep_mode),
    .sleep_req_i(sleep_req),
    .sleep_ack_o(sleep_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni     = 1'b0;
    pad_in     = '0;
    core_out   = '0;
    core_oe    = '0;
    attr       = '0;
    deb_en     = '0;
    deb_thr    = 8'd4;
    sleep_mode = '0;
    sleep_req  = 1'b0;

    // Reset state
    step(2);
    chk("rst_core_in", 32'(core_in), 32'h0);
    chk("rst_pad_out", 32'(pad_out), 32'h0);
    chk("rst_pad_oe", 32'(pad_oe), 32'h0);
    chk("rst_pad_attr", pad_attr, 32'h0);
    chk("rst_ack", 32'(sleep_ack), 32'h0);
    rst_ni = 1'b1;
    step(3);

    // Synchroniser only: change after edge 0, visible after edge 3
    pad_in = 4'b0100;
    step(2);
    chk("sync_edge2", 32'(core_in), 32'h0);
    step(1);
    chk("sync_edge3", 32'(core_in), 32'h4);
    pad_in = 4'b0000;
    step(4);
    chk("sync_back0", 32'(core_in), 32'h0);

    // Debounce: 3-cycle glitch is rejected
    deb_en = 4'b0010;
    deb_thr = 8'd4;
    pad_in = 4'b0010;
    step(3);
    pad_in = 4'b0000;
    step(8);
    chk("deb_glitch", 32'(core_in), 32'h0);

    // Debounce: 10-cycle high rises 6 cycles after the input edge
    pad_in = 4'b0010;
    step(5);
    chk("deb_edge5", 32'(core_in), 32'h0);
    step(1);
    chk("deb_edge6", 32'(core_in), 32'h2);
    step(4);
    pad_in = 4'b0000;
    step(8);
    chk("deb_fall", 32'(core_in), 32'h0);

    // Retention setup and live pass-through
    deb_en     = 4'b0000;
    core_out   = 4'b1010;
    core_oe    = 4'b1111;
    attr       = 32'hA5A5_5A5A;
    sleep_mode = {2'd3, 2'd2, 2'd1, 2'd0};
    step(1);
    chk("live_out", 32'(pad_out), 32'hA);
    chk("live_oe", 32'(pad_oe), 32'hF);
    chk("live_attr", pad_attr, 32'hA5A5_5A5A);

    // Request sleep at edge n
    sleep_req = 1'b1;
    step(1);
    chk("freeze_ack", 32'(sleep_ack), 32'h0);
    core_out = 4'b0000;
    attr     = 32'h0000_0000;
    step(1);
    chk("sleep_ack", 32'(sleep_ack), 32'h1);
    chk("ret_out", 32'(pad_out), 32'hA);
    chk("ret_oe", 32'(pad_oe), 32'hD);
    chk("ret_attr", pad_attr, 32'hA5A5_5A5A);

    // Live mode change during SLEEP: all tristate
    sleep_mode = {2'd1, 2'd1, 2'd1, 2'd1};
    step(1);
    chk("mode1_oe", 32'(pad_oe), 32'h0);
    chk("mode1_out", 32'(pad_out), 32'hA);
    sleep_mode = {2'd3, 2'd2, 2'd1, 2'd0};

    // Inputs toggled in SLEEP do not reach the core
    pad_in = 4'b1111;
    step(4);
    chk("sleep_core_in", 32'(core_in), 32'h0);
    chk("sleep_ack_hold", 32'(sleep_ack), 32'h1);

    // Wake: release at edge m
    sleep_req = 1'b0;
    step(1);
    chk("wake_ack", 32'(sleep_ack), 32'h0);
    step(2);
    chk("wake_core_in", 32'(core_in), 32'h0);
    chk("wake_ret_out", 32'(pad_out), 32'hA);
    step(1);
    chk("act_core_in", 32'(core_in), 32'hF);
    chk("act_out", 32'(pad_out), 32'h0);
    chk("act_oe", 32'(pad_oe), 32'hF);
    chk("act_attr", pad_attr, 32'h0);

    // One-cycle request pulse, then reassert during WAKE
    core_out = 4'b0101;
    attr     = 32'h1234_5678;
    step(1);
    sleep_req = 1'b1;
    step(1);
    sleep_req = 1'b0;
    chk("pulse_freeze_ack", 32'(sleep_ack), 32'h0);
    step(1);
    chk("pulse_sleep_ack", 32'(sleep_ack), 32'h1);
    step(1);
    chk("pulse_wake_ack", 32'(sleep_ack), 32'h0);
    sleep_req = 1'b1;
    step(1);
    chk("wake2_ack", 32'(sleep_ack), 32'h0);
    step(1);
    chk("wake_end_ack", 32'(sleep_ack), 32'h0);
    chk("wake_end_out", 32'(pad_out), 32'h9);
    step(1);
    chk("reenter_live_out", 32'(pad_out), 32'h5);
    chk("reenter_freeze_ack", 32'(sleep_ack), 32'h0);
    step(1);
    chk("reenter_sleep_ack", 32'(sleep_ack), 32'h1);
    chk("reenter_ret_out", 32'(pad_out), 32'h9);
    chk("reenter_ret_oe", 32'(pad_oe), 32'hD);
    chk("reenter_attr", pad_attr, 32'h1234_5678);

    // Mode 3 in SLEEP, then asynchronous reset between edges
    sleep_mode = 8'hFF;
    step(1);
    chk("mode3_out", 32'(pad_out), 32'hF);
    chk("mode3_oe", 32'(pad_oe), 32'hF);
    chk("mode3_core_in", 32'(core_in), 32'hF);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_out", 32'(pad_out), 32'h0);
    chk("arst_oe", 32'(pad_oe), 32'h0);
    chk("arst_ack", 32'(sleep_ack), 32'h0);
    chk("arst_core_in", 32'(core_in), 32'h0);
    chk("arst_attr", pad_attr, 32'h0);
    sleep_req = 1'b0;
    step(1);
    rst_ni = 1'b1;
    step(1);
    chk("post_rst_out", 32'(pad_out), 32'h5);
    chk("post_rst_ack", 32'(sleep_ack), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pad_io_ctrl.md
# pad_io_ctrl

Parametrised, clocked pad-control layer between the core and the pad wrapper instances. It synchronises and optionally debounces every pad input, and registers the core's output, output-enable and attribute controls toward the pads. A sleep/retention handshake freezes pad state and forces each pad to a configurable retention behaviour while the core is powered down or held. It replaces direct core-to-pad wiring for all multiplexed and dedicated pads.

## Interface
- NPads, 20, number of pads handled (MIO + DIO)
- AttrDw, 8, attribute bits per pad
- SyncStages, 2, input synchroniser depth (>=2)
- DebW, 8, debounce threshold width

- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- pad_in_i  in  NPads  raw pad input (from pad wrapper in_o)
- core_in_o  out  NPads  synchronised/debounced input to core
- core_out_i  in  NPads  core output data
- core_oe_i  in  NPads  core output enable
- attr_i  in  NPads*AttrDw  core pad attributes, pad k at [k*AttrDw +: AttrDw]
- pad_out_o  out  NPads  to pad wrapper out_i
- pad_oe_o  out  NPads  to pad wrapper oe_i
- pad_attr_o  out  NPads*AttrDw  to pad wrapper attr_i
- deb_en_i  in  NPads  per-pad debounce enable
- deb_thr_i  in  DebW  global debounce threshold (cycles)
- sleep_mode_i  in  NPads*2  per-pad retention mode: 0 hold, 1 tristate, 2 drive 0, 3 drive 1
- sleep_req_i  in  1  level request to enter retention
- sleep_ack_o  out  1  high only in SLEEP

## Operation
- Reset: all synchroniser flops, core_in_o, debounce counters, and hold regs = 0; state ACTIVE; sleep_ack_o=0; pad_out_o/pad_oe_o/pad_attr_o=0.
- Input path per pad: SyncStages-flop synchroniser, then registered core_in_o.
  - deb_en_i=0: core_in_o <= synced value every cycle.
  - deb_en_i=1: counter increments each cycle synced != core_in_o; clears when equal. core_in_o takes the synced value on the edge where mismatch has persisted deb_thr_i consecutive cycles. deb_thr_i=0 is treated as 1. Counter width DebW; no wrap possible because it clears on update.
- Output path (ACTIVE): pad_out_o/pad_oe_o/pad_attr_o are registered copies of core_out_i/core_oe_i/attr_i, one cycle latency.
- FSM states: ACTIVE, FREEZE, SLEEP, WAKE.
  - ACTIVE -> FREEZE when sleep_req_i=1. On this edge, hold regs capture core_out_i, core_oe_i, attr_i.
  - FREEZE -> SLEEP unconditionally after 1 cycle.
  - SLEEP -> WAKE when sleep_req_i=0.
  - WAKE lasts SyncStages cycles (refill counter), then -> ACTIVE.
- In FREEZE, SLEEP and WAKE:
  - pad_attr_o = held attr.
  - Per pad, by mode:
    - mode 0: out/oe = held values.
    - mode 1: oe=0, out=held.
    - mode 2: oe=1, out=0.
    - mode 3: oe=1, out=1.
  - core_in_o is frozen and debounce counters are held at 0. Synchronisers keep sampling.
- sleep_req_i deasserted during FREEZE: SLEEP is still entered; ack is high for at least 1 cycle, then WAKE.
- sleep_req_i asserted during WAKE: ignored until ACTIVE, then re-enters FREEZE on the next edge.
- sleep_mode_i is sampled live; changes during SLEEP take effect next cycle.
- Asynchronous reset mid-sequence: immediate return to reset values and ACTIVE.

## Timing
- pad_in_i -> core_in_o: SyncStages+1 cycles (no debounce); SyncStages+max(deb_thr_i,1) cycles (debounce, stable input).
- core_out_i/core_oe_i/attr_i -> pads: 1 cycle in ACTIVE.
- sleep_req_i rise at edge n:
  - state FREEZE after edge n.
  - Retention outputs registered after edge n+1.
  - SLEEP and sleep_ack_o=1 after edge n+1.
- sleep_req_i fall observed in SLEEP at edge m:
  - ack=0 after edge m.
  - ACTIVE after edge m+SyncStages.
  - Live outputs registered one edge later.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset: assert rst_ni=0 mid-SLEEP with mode 3 -> pad_oe_o=0, pad_out_o=0, sleep_ack_o=0, core_in_o=0 immediately, without waiting for a clock edge.
- Sync only: NPads=4, deb_en_i=0, pad_in_i[2] 0->1 at edge 0 -> core_in_o[2]=1 after edge 3 (SyncStages=2).
- Debounce: deb_en_i[1]=1, deb_thr_i=4.
  - 3-cycle high glitch on pad_in_i[1] -> core_in_o[1] stays 0.
  - 10-cycle high -> core_in_o[1] rises 6 cycles after the input edge.
- Retention:
  - Setup: core_out_i=4'b1010, core_oe_i=4'b1111, sleep_mode_i={3,2,1,0} (pad3..pad0).
  - Raise sleep_req_i, then change core_out_i to 0 -> in SLEEP, pad_out_o=4'b1010 on pad3..pad0, pad_oe_o=4'b1101.
  - pad_attr_o unchanged when attr_i is altered.
- Handshake edges:
  - 1-cycle sleep_req_i pulse -> sleep_ack_o high exactly 1 cycle, then 2 WAKE cycles, then ACTIVE.
  - Request reasserted during WAKE -> FREEZE on the first edge after ACTIVE.
- Freeze of inputs: toggle pad_in_i during SLEEP -> core_in_o constant; after wake, core_in_o reflects the new level within SyncStages+1 cycles of ACTIVE.
